// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel runtime divisor reload,
// enable and a global phase-align strobe. Optional build macro: ODD_DUTY50_EN.
module clk_div_multi #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clockin,
  input  logic             rst_n,
  input  logic [NCH-1:0]   chan_en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_chan,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCH-1:0]   clockout,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  logic [31:0]      chan_idx;
  logic             accept;
  logic [WIDTH-1:0] cfg_div_clamped;

  assign chan_idx = 32'(cfg_chan);

  // A channel holding an unapplied divisor refuses further loads until it applies.
  always_comb begin
    cfg_ready = 1'b0;
    if (chan_idx < NCH) cfg_ready = ~pending[cfg_chan];
  end

  assign accept          = cfg_valid & cfg_ready;
  assign cfg_div_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] high_len;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             terminal;
    logic             load_here;

    // ceil(D/2) without forming D+1, so D = 2^WIDTH-1 cannot overflow.
    assign high_len  = (div_q >> 1) + WIDTH'(div_q[0]);
    assign terminal  = (cnt_q == div_q - WIDTH'(1));
    assign load_here = accept && (cfg_chan == CW'(i));

    // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
      div_d      = div_q;
      pend_div_d = pend_div_q;
      pending_d  = pending_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      tick_d     = tick_q;
      if (sync || !chan_en[i]) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (pending_q) begin
          div_d     = pend_div_q;
          pending_d = 1'b0;
        end
      end else begin
        clk_d  = (cnt_q < high_len);
        tick_d = terminal;
        cnt_d  = terminal ? '0 : cnt_q + WIDTH'(1);
        if (terminal && pending_q) begin
          div_d     = pend_div_q;
          pending_d = 1'b0;
        end
      end
      // Load is evaluated last: a capture on an apply edge waits for the next boundary.
      if (load_here) begin
        pend_div_d = cfg_div_clamped;
        pending_d  = 1'b1;
      end
    end

    // NOTE: these per-channel registers are plain flops, so all of them take the async reset.
    always_ff @(posedge clockin or negedge rst_n) begin
      if (!rst_n) begin
        div_q      <= WIDTH'(DEFAULT_DIV);
        pend_div_q <= WIDTH'(DEFAULT_DIV);
        pending_q  <= 1'b0;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        div_q      <= div_d;
        pend_div_q <= pend_div_d;
        pending_q  <= pending_d;
        cnt_q      <= cnt_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

`ifdef ODD_DUTY50_EN
    logic clk_neg_q;

    // Half-cycle delayed copy trims the odd-divisor high phase to exactly D/2.
    always_ff @(negedge clockin or negedge rst_n) begin
      if (!rst_n) clk_neg_q <= 1'b0;
      else        clk_neg_q <= clk_q;
    end

    assign clockout[i] = div_q[0] ? (clk_q & clk_neg_q) : clk_q;
`else
    assign clockout[i] = clk_q;
`endif
    assign tick[i]    = tick_q;
    assign pending[i] = pending_q;
  end

endmodule
